store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Load/store front end sitting directly upstream of the single-port data memory in the OoO pipe.
- Holds committed stores in a FIFO and drains them to memory when the port is free.
- Services speculative loads either from memory or by store-to-load forwarding from buffered stores.
- Owns the memory port; at most one memory operation per cycle.

Parameters:
DEPTH, 8, store entries (power of 2)
ADDR_W, 14, word address width
DATA_W, 32, data width
TAG_W, 6, load ROB tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
st_valid  in  1  committed store request
st_ready  out  1  store accepted when st_valid & st_ready
st_addr  in  ADDR_W  store address
st_data  in  DATA_W  store data
ld_valid  in  1  load request
ld_ready  out  1  load accepted when ld_valid & ld_ready
ld_addr  in  ADDR_W  load address
ld_tag  in  TAG_W  load ROB tag
flush  in  1  pipeline flush; kills loads only
ld_resp_valid  out  1  load result valid
ld_resp_tag  out  TAG_W  tag of returning load
ld_resp_data  out  DATA_W  load data
mem_en  out  1  memory read enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en
sb_empty  out  1  no buffered stores (fence support)

Behaviour:
- State: circular FIFO of {addr,data}, head/tail pointers with wrap at DEPTH, count 0..DEPTH. Reset: pointers 0, count 0, response register cleared; outputs then ld_resp_valid=0, mem_en=0, mem_we=0, sb_empty=1, st_ready=1, ld_ready=1.
- full = (count==DEPTH). st_ready = ~full. ld_ready = ~full & ~flush. Ready signals never depend on the valid inputs.
- Forwarding search on load acceptance covers the incoming store in the same cycle (youngest) plus all buffered entries, youngest to oldest. It includes the head entry even when that entry is draining in this cycle. Full-word match only.
- Load hit: no memory access. Forwarded data is registered.
- Load miss: mem_en=1, mem_we=0, mem_addr=ld_addr for that cycle.
- Drain: if count>0 and no load miss owns the port, mem_we=1, mem_en=0, mem_addr/mem_wdata come from the head entry, and head advances. A load hit does not block drain.
- When full, loads are blocked, so drain always proceeds. This guarantees forward progress.
- Push and pop in the same cycle leave count unchanged. There is no push when full, even if a pop occurs in the same cycle.
- Load latency: accepted in cycle N, ld_resp_valid=1 in cycle N+1 with the captured tag.
- ld_resp_data: forwarded register on a hit; mem_rdata on a miss (combinational mux).
- Memory is write-before-read safe: a drain and a miss are never in the same cycle, and a write at edge N is visible to a read in N+1.
- flush: ld_resp_valid = resp_q & ~flush, so flush suppresses the response emerging that cycle. flush blocks load acceptance but does not affect stores, the FIFO, or draining.
- Reset mid-operation: buffered stores are discarded and the in-flight response is dropped. Memory outputs go inactive immediately (asynchronous).

Decomposition:
- sb_pkg: ADDR_W/DATA_W/TAG_W defaults and typedef sb_entry_t {addr, data}.
- One sub-module, sb_fwd_match: youngest-first priority match over the entries plus the incoming store. Outputs hit and data. Purely combinational.

Test Plan:
- Reset, push stores 0x0010/0x11111111, 0x0011/0x22222222, 0x0012/0x33333333 with no loads -> mem_we pulses in push order one per cycle, correct addr/data each time, sb_empty=1 after the last drain.
- Buffer 0x0020/0xDEADBEEF while back-to-back load misses to 0x0100 hold the port, then load 0x0020 tag 5 -> next cycle ld_resp_valid=1, tag 5, data 0xDEADBEEF; mem_en=0 in the load cycle; drain proceeds that cycle.
- Buffer 0x0030/0x1 then 0x0030/0x2, load 0x0030 -> 0x2 (youngest wins). After both drain, load 0x0030 misses and returns 0x2 from memory.
- Same-cycle store 0x0040/0x0000CAFE and load 0x0040 -> response 0x0000CAFE.
- Fill 8 entries under continuous load-miss pressure -> st_ready=0 and ld_ready=0 at count=8. Next cycle a drain occurs and count=7.
- Load miss accepted in cycle N, flush=1 in N+1 -> ld_resp_valid=0 in N+1. Assert rst during a drain -> count=0, mem_we=0 immediately, sb_empty=1.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared widths and the buffered-store entry layout for the store buffer.
// No logic; types and defaults only.
// Entry widths below set the storage layout used by store_buffer.
package sb_pkg;

    localparam int SB_DEPTH  = 8;
    localparam int SB_ADDR_W = 14;
    localparam int SB_DATA_W = 32;
    localparam int SB_TAG_W  = 6;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding match: youngest matching store wins (incoming store, then buffer tail to head).
// Latency: purely combinational.
// Backpressure: none; caller qualifies st_push and uses hit only on an accepted load.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]      head,
    input  logic [CNT_W-1:0]      count,
    input  logic                  st_push,
    input  sb_entry_t             st_entry,
    input  logic [SB_ADDR_W-1:0]  ld_addr,
    output logic                  hit,
    output logic [SB_DATA_W-1:0]  data
);

    // Walk live entries oldest to youngest so later matches override earlier ones;
    // the same-cycle store is the youngest of all and is applied last.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (entries[head + PTR_W'(i)].addr == ld_addr)) begin
                hit  = 1'b1;
                data = entries[head + PTR_W'(i)].data;
            end
        end
        if (st_push && (st_entry.addr == ld_addr)) begin
            hit  = 1'b1;
            data = st_entry.data;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO in front of a single-port data memory, with store-to-load forwarding.
// Latency: load response one cycle after acceptance; a buffered store drains no earlier than the cycle after push.
// Backpressure: st_ready drops only when full; ld_ready drops when full or on flush; a load miss stalls draining.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    parameter int TAG_W  = SB_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic              flush,
    output logic              ld_resp_valid,
    output logic [TAG_W-1:0]  ld_resp_tag,
    output logic [DATA_W-1:0] ld_resp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t [DEPTH-1:0] fifo_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;

    logic              resp_q;
    logic              resp_hit_q;
    logic [TAG_W-1:0]  resp_tag_q;
    logic [DATA_W-1:0] resp_fwd_q;

    logic              full;
    logic              st_push;
    logic              ld_take;
    logic              ld_miss;
    logic              drain;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    sb_entry_t         st_entry;
    sb_entry_t         head_entry;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign st_ready   = ~full;
    assign ld_ready   = ~full & ~flush;
    assign st_push    = st_valid & st_ready;
    assign ld_take    = ld_valid & ld_ready;
    assign st_entry   = '{addr: st_addr, data: st_data};
    assign head_entry = fifo_q[head_q];
    assign sb_empty   = (count_q == '0);

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries  (fifo_q),
        .head     (head_q),
        .count    (count_q),
        .st_push  (st_push),
        .st_entry (st_entry),
        .ld_addr  (ld_addr),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    // A missing load owns the port; otherwise the head store drains. When full no load
    // is accepted, so draining always makes progress.
    assign ld_miss   = ld_take & ~fwd_hit;
    assign drain     = (count_q != '0) & ~ld_miss;
    // Gated by rst so the port goes quiet the moment reset asserts, not at the next edge.
    assign mem_en    = ld_miss & ~rst;
    assign mem_we    = drain & ~rst;
    assign mem_addr  = ld_miss ? ld_addr : head_entry.addr;
    assign mem_wdata = head_entry.data;

    assign ld_resp_valid = resp_q & ~flush;
    assign ld_resp_tag   = resp_tag_q;
    assign ld_resp_data  = resp_hit_q ? resp_fwd_q : mem_rdata;

    // Store payload array; contents are meaningless outside head..tail, so no reset.
    always_ff @(posedge clk) begin
        if (st_push) begin
            fifo_q[tail_q] <= st_entry;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (st_push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (drain) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (st_push && !drain) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!st_push && drain) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Capture the accepted load's tag and, on a hit, its forwarded data for next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q     <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_tag_q <= '0;
            resp_fwd_q <= '0;
        end else begin
            resp_q <= ld_take;
            if (ld_take) begin
                resp_hit_q <= fwd_hit;
                resp_tag_q <= ld_tag;
                resp_fwd_q <= fwd_data;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against a last-store-wins memory view and a pending-store queue.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_store_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int TW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid, st_ready, ld_valid, ld_ready, flush;
    logic [AW-1:0] st_addr, ld_addr, mem_addr;
    logic [DW-1:0] st_data, ld_resp_data, mem_wdata, mem_rdata;
    logic [TW-1:0] ld_tag, ld_resp_tag;
    logic          ld_resp_valid, mem_en, mem_we, sb_empty;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
        .flush(flush),
        .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag), .ld_resp_data(ld_resp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .sb_empty(sb_empty)
    );

    // ---------------- memory behind the port ----------------
    logic [DW-1:0] tbmem   [int];
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    function automatic logic [DW-1:0] mem_rd(input int a);
        if (tbmem.exists(a)) return tbmem[a];
        return init_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_we) tbmem[int'(mem_addr)] = mem_wdata;
        if (mem_en) mem_rdata = mem_rd(int'(mem_addr));
    end

    // ---------------- checking ----------------
    int ncmp = 0;
    int nerr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stores not yet written to memory, and the pending response.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;
    st_t           sq[$];
    logic          rp;
    logic [TW-1:0] rp_tag;
    logic [DW-1:0] rp_data;

    // Evaluate one cycle with the inputs currently applied, then advance the model.
    task automatic model_cycle();
        int n;
        bit sacc, lacc, hit, miss, ewe;
        n    = sq.size();
        sacc = st_valid && (n < DEPTH);
        lacc = ld_valid && (n < DEPTH) && !flush;
        check("st_ready", st_ready, 32'(n < DEPTH));
        check("ld_ready", ld_ready, 32'((n < DEPTH) && !flush));
        check("sb_empty", sb_empty, 32'(n == 0));
        check("resp_valid", ld_resp_valid, 32'(rp && !flush));
        if (rp && !flush) begin
            check("resp_tag", ld_resp_tag, rp_tag);
            check("resp_data", ld_resp_data, rp_data);
        end
        hit = 1'b0;
        if (lacc) begin
            if (sacc && st_addr == ld_addr) hit = 1'b1;
            foreach (sq[i]) if (sq[i].a == ld_addr) hit = 1'b1;
        end
        miss = lacc && !hit;
        ewe  = (n > 0) && !miss;
        check("mem_en", mem_en, 32'(miss));
        check("mem_we", mem_we, 32'(ewe));
        if (miss) check("miss_addr", mem_addr, ld_addr);
        if (ewe) begin
            check("drain_addr", mem_addr, sq[0].a);
            check("drain_data", mem_wdata, sq[0].d);
            void'(sq.pop_front());
        end
        if (sacc) begin
            ref_mem[int'(st_addr)] = st_data;
            sq.push_back('{st_addr, st_data});
        end
        rp = lacc;
        if (lacc) begin
            rp_tag  = ld_tag;
            rp_data = ref_rd(int'(ld_addr));
        end
    endtask

    task automatic model_reset();
        sq.delete();
        rp = 1'b0;
        ref_mem.delete();
        foreach (tbmem[k]) ref_mem[k] = tbmem[k];
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          sv;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          lv;
        logic [AW-1:0] la;
        logic [TW-1:0] lt;
        logic          fl;
        logic          chk;
        logic          e_we;
        logic          e_en;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_rv;
        logic [TW-1:0] e_tag;
        logic [DW-1:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic sv, input int sa, input logic [DW-1:0] sd,
                                input logic lv, input int la, input int lt, input logic fl,
                                input logic e_we, input logic e_en, input int e_addr,
                                input logic [DW-1:0] e_wdata, input logic e_rv,
                                input int e_tag, input logic [DW-1:0] e_rdata);
        vec_t v;
        v.sv = sv; v.sa = AW'(sa); v.sd = sd;
        v.lv = lv; v.la = AW'(la); v.lt = TW'(lt); v.fl = fl; v.chk = 1'b1;
        v.e_we = e_we; v.e_en = e_en; v.e_addr = AW'(e_addr); v.e_wdata = e_wdata;
        v.e_rv = e_rv; v.e_tag = TW'(e_tag); v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        st_valid = v.sv; st_addr = v.sa; st_data = v.sd;
        ld_valid = v.lv; ld_addr = v.la; ld_tag = v.lt; flush = v.fl;
        #1;
        if (v.chk) begin
            check({nm, "_we"}, mem_we, 32'(v.e_we));
            check({nm, "_en"}, mem_en, 32'(v.e_en));
            if (v.e_we || v.e_en) check({nm, "_addr"}, mem_addr, v.e_addr);
            if (v.e_we) check({nm, "_wdata"}, mem_wdata, v.e_wdata);
            check({nm, "_rv"}, ld_resp_valid, 32'(v.e_rv));
            if (v.e_rv) begin
                check({nm, "_tag"}, ld_resp_tag, v.e_tag);
                check({nm, "_rdata"}, ld_resp_data, v.e_rdata);
            end
        end
        model_cycle();
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst = 1'b1;
        st_valid = 0; st_addr = '0; st_data = '0;
        ld_valid = 0; ld_addr = '0; ld_tag = '0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", ld_resp_valid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_sb_empty", sb_empty, 1);
        check("rst_st_ready", st_ready, 1);
        check("rst_ld_ready", ld_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        //          sv sa     sd             lv la     lt fl  we en addr   wdata          rv tag rdata
        tbl.push_back(mk(1, 'h10, 32'h11111111, 0, 0,     0, 0,  0, 0, 0,     0,             0, 0,  0));
        tbl.push_back(mk(1, 'h11, 32'h22222222, 0, 0,     0, 0,  1, 0, 'h10,  32'h11111111,  0, 0,  0));
        tbl.push_back(mk(1, 'h12, 32'h33333333, 0, 0,     0, 0,  1, 0, 'h11,  32'h22222222,  0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 0,  1, 0, 'h12,  32'h33333333,  0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 0,  0, 0, 0,     0,             0, 0,  0));
        tbl.push_back(mk(1, 'h20, 32'hDEADBEEF, 1, 'h100, 1, 0,  0, 1, 'h100, 0,             0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            1, 'h100, 2, 0,  0, 1, 'h100, 0,             1, 1,  32'hC0DE0100));
        tbl.push_back(mk(0, 0,    0,            1, 'h20,  5, 0,  1, 0, 'h20,  32'hDEADBEEF,  1, 2,  32'hC0DE0100));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 0,  0, 0, 0,     0,             1, 5,  32'hDEADBEEF));
        tbl.push_back(mk(1, 'h30, 32'h1,        0, 0,     0, 0,  0, 0, 0,     0,             0, 0,  0));
        tbl.push_back(mk(1, 'h30, 32'h2,        1, 'h100, 8, 0,  0, 1, 'h100, 0,             0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            1, 'h30,  7, 0,  1, 0, 'h30,  32'h1,         1, 8,  32'hC0DE0100));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 0,  1, 0, 'h30,  32'h2,         1, 7,  32'h2));
        tbl.push_back(mk(0, 0,    0,            1, 'h30,  9, 0,  0, 1, 'h30,  0,             0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 0,  0, 0, 0,     0,             1, 9,  32'h2));
        tbl.push_back(mk(1, 'h40, 32'h0000CAFE, 1, 'h40,  10,0,  0, 0, 0,     0,             0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 0,  1, 0, 'h40,  32'h0000CAFE,  1, 10, 32'h0000CAFE));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 0,  0, 0, 0,     0,             0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            1, 'h200, 11,0,  0, 1, 'h200, 0,             0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 1,  0, 0, 0,     0,             0, 0,  0));
        tbl.push_back(mk(0, 0,    0,            0, 0,     0, 0,  0, 0, 0,     0,             0, 0,  0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Fill to DEPTH while load misses hold the port.
        for (int k = 0; k < DEPTH; k++) begin
            v = mk(1, 'h50 + k, 32'hF0000000 + 32'(k), 1, 'h300, 20 + k, 0, 0, 1, 'h300, 0, 0, 0, 0);
            v.chk = 1'b0;
            step(v, "fill");
        end
        step(mk(1, 'h58, 32'hF0000008, 1, 'h301, 30, 0, 1, 0, 'h50, 32'hF0000000, 1, 27, 32'hC0DE0300), "full");
        check("full_st_ready", st_ready, 0);
        check("full_ld_ready", ld_ready, 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h51, 32'hF0000001, 0, 0, 0), "after_full");
        check("after_full_st_ready", st_ready, 1);

        // Reset asserted mid-cycle while a drain is on the port.
        @(negedge clk);
        st_valid = 0; ld_valid = 0; flush = 0;
        #1;
        check("pre_rst_we", mem_we, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_en", mem_en, 0);
        check("mid_rst_empty", sb_empty, 1);
        check("mid_rst_st_ready", st_ready, 1);
        check("mid_rst_resp_valid", ld_resp_valid, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        // Discarded store must not be visible: load misses and returns the memory value.
        step(mk(0, 0, 0, 1, 'h53, 40, 0, 0, 1, 'h53, 0, 0, 0, 0), "post_rst_ld");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 40, 32'hC0DE0053), "post_rst_resp");

        // Randomized traffic on a small address window to provoke aliasing.
        for (int c = 0; c < 4000; c++) begin
            v.chk = 1'b0;
            v.sv  = ($urandom_range(0, 99) < (c < 2000 ? 75 : 45));
            v.sa  = AW'('h60 + $urandom_range(0, 7));
            v.sd  = $urandom;
            v.lv  = ($urandom_range(0, 99) < (c < 2000 ? 85 : 50));
            v.la  = AW'('h60 + $urandom_range(0, 7));
            v.lt  = TW'($urandom);
            v.fl  = ($urandom_range(0, 9) == 0);
            step(v, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
